// File: rtl/root_5_en_multi_cycle.sv
// Integer fifth root, floor(arg^(1/5)), by MSB-first bit search over RW root bits.
// Each bit needs 4 shared-multiplier steps plus one compare, so a result appears 5*RW enabled edges after acceptance.
module root_5_en_multi_cycle #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic         arg_vld,
  input  logic [w-1:0] arg,
  output logic         arg_rdy,
  output logic         res_vld,
  output logic [w-1:0] res
);

  localparam int RW = (w + 4) / 5;
  localparam int PW = 5 * RW;
  localparam int BW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [w-1:0]    arg_q;
  logic [RW-1:0]   root_q;
  logic [BW-1:0]   bit_idx;
  logic [1:0]      mcnt;
  logic [PW-1:0]   mul_q;

  logic [RW-1:0]   bit_mask;
  logic [RW-1:0]   cand;
  logic [PW-1:0]   cand_ext;
  logic [PW-1:0]   mul_a;
  logic [PW-1:0]   prod;
  logic            fit;
  logic [RW-1:0]   root_nxt;
  logic            accept;

  assign arg_rdy  = (state_q == IDLE);
  assign accept   = arg_vld && arg_rdy;
  assign bit_mask = RW'(1) << bit_idx;
  assign cand     = root_q | bit_mask;
  assign cand_ext = PW'(cand);

  // Single multiplier: first step squares the candidate, later steps fold in one more factor.
  assign mul_a    = (mcnt == 2'd0) ? cand_ext : mul_q;
  assign prod     = mul_a * cand_ext;

  assign fit      = (mul_q <= PW'(arg_q));
  assign root_nxt = fit ? (root_q | bit_mask) : root_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arg_vld) state_d = MUL;
      MUL:  if (mcnt == 2'd3) state_d = CMP;
      CMP:  state_d = (bit_idx == '0) ? IDLE : MUL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root_q  <= '0;
      bit_idx <= BW'(RW - 1);
      mcnt    <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else if (clk_en) begin
      res_vld <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            root_q  <= '0;
            bit_idx <= BW'(RW - 1);
            mcnt    <= '0;
          end
        end
        MUL: begin
          mcnt <= (mcnt == 2'd3) ? 2'd0 : mcnt + 2'd1;
        end
        CMP: begin
          root_q <= root_nxt;
          if (bit_idx == '0) begin
            res     <= w'(root_nxt);
            res_vld <= 1'b1;
          end else begin
            bit_idx <= bit_idx - BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and product registers are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (accept) arg_q <= arg;
      if (state_q == MUL) mul_q <= prod;
    end
  end

endmodule
